// File: rtl/square_seq.sv
`default_nettype none
// ============================================================================
// Module      : square_seq
// Description : Sequential fixed-point squarer. Squares an unsigned 8.8
//               operand into an exact unsigned 16.16 result with a
//               shift-add datapath, one multiplier bit per cycle.
//               Integer parts are also given truncated and rounded half up.
//               A start/busy/done handshake controls it.
//
// Ports
//   clk       in   1        system clock, rising edge
//   rst_n     in   1        synchronous reset, active low
//   start     in   1        operation request, honoured only when idle
//   in        in   WIDTH    operand, unsigned 8.8, captured on acceptance
//   busy      out  1        high while the shift-add loop runs
//   done      out  1        one-cycle pulse when square is updated
//   square    out  2*WIDTH  exact product, unsigned 16.16, held until the
//                           next done
//   sq_int    out  WIDTH    square[31:16], truncated integer part
//   sq_round  out  WIDTH    square[31:16] + square[15], rounded half up
//
// Revision    : 1.0 - initial release
// ============================================================================
module square_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   square,
    output logic [WIDTH-1:0]     sq_int,
    output logic [WIDTH-1:0]     sq_round
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_a;       // multiplicand, shifted left each cycle
    logic [WIDTH-1:0]     r_b;       // multiplier, shifted right each cycle
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_square;
    logic                 r_busy;
    logic                 r_done;

    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Partial product for the current multiplier bit. The accumulator
    // cannot overflow: the largest product is (2^WIDTH-1)^2.
    assign w_addend   = r_b[0] ? r_a : '0;
    assign w_acc_next = r_acc + w_addend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_square <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                // The edge that leaves DONE is also the first edge at which
                // a new request may be taken, so a held start yields one
                // result every 17 cycles. Requests seen during CALC never
                // reach this branch and are dropped, not queued.
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= {{WIDTH{1'b0}}, in};
                        r_b     <= in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // Publish the final sum including this cycle's
                        // partial product; the output register only ever
                        // sees complete results.
                        r_square <= w_acc_next;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign square   = r_square;
    assign sq_int   = r_square[2*WIDTH-1:WIDTH];
    // Cannot overflow: the top half of a maximal square is 2^WIDTH-2.
    assign sq_round = r_square[2*WIDTH-1:WIDTH]
                    + {{(WIDTH-1){1'b0}}, r_square[WIDTH-1]};

endmodule
`default_nettype wire

// File: tb/tb_square_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_square_seq
// Description : Self-checking bench for square_seq. Expected results are
//               queued when an operation is launched and compared when the
//               design pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_square_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in;
    logic        busy;
    logic        done;
    logic [31:0] square;
    logic [15:0] sq_int;
    logic [15:0] sq_round;

    square_seq #(.WIDTH(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in       (in),
        .busy     (busy),
        .done     (done),
        .square   (square),
        .sq_int   (sq_int),
        .sq_round (sq_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   last_done_cyc = -1;
    bit   contin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                check("busy_with_done", {31'b0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t        e;
                    logic [31:0] esq;
                    e   = sb.pop_front();
                    esq = {16'b0, e.op} * {16'b0, e.op};
                    check("square",   square,          esq);
                    check("sq_int",   {16'b0, sq_int}, {16'b0, esq[31:16]});
                    check("sq_round", {16'b0, sq_round},
                          {16'b0, esq[31:16] + {15'b0, esq[15]}});
                    check("latency",  32'(cyc - e.acc_cyc), 32'd16);
                    check("busy_len", 32'(busy_cnt), 32'd16);
                    if (contin && last_done_cyc >= 0)
                        check("done_spacing", 32'(cyc - last_done_cyc), 32'd17);
                end
                busy_cnt      = 0;
                last_done_cyc = cyc;
            end
        end
    end

    // Launch one operation from idle; in is scrambled afterwards to show
    // that only the accepting edge matters.
    task automatic start_op(input logic [15:0] v);
        @(negedge clk);
        start = 1'b1;
        in    = v;
        @(posedge clk);
        @(negedge clk);
        sb.push_back('{v, cyc});
        start = 1'b0;
        in    = 16'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in    = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy",     {31'b0, busy}, 32'd0);
        check("rst_done",     {31'b0, done}, 32'd0);
        check("rst_square",   square,        32'd0);
        check("rst_sq_int",   {16'b0, sq_int},   32'd0);
        check("rst_sq_round", {16'b0, sq_round}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operands, including rounding and extremes.
        start_op(16'h0200); wait_drain();
        start_op(16'h0180); wait_drain();
        start_op(16'h016A); wait_drain();
        start_op(16'hFFFF); wait_drain();
        start_op(16'h0000); wait_drain();

        // Requests during CALC (sampled at E5 and E16) are ignored.
        start_op(16'h0300);
        repeat (3) @(negedge clk);          // now just after E3
        @(negedge clk); start = 1'b1; in = 16'h0100;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        @(negedge clk); start = 1'b1; in = 16'h0100;
        @(negedge clk); start = 1'b0;
        repeat (25) @(negedge clk);         // any extra done is flagged
        check("ignore_drained", 32'(sb.size()), 32'd0);
        start_op(16'h0100); wait_drain();

        // Reset in the middle of an operation.
        start_op(16'hFFFF);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        check("midrst_busy",   {31'b0, busy}, 32'd0);
        check("midrst_square", square,        32'd0);
        check("midrst_sq_int", {16'b0, sq_int}, 32'd0);
        repeat (25) @(negedge clk);
        start_op(16'h0A00); wait_drain();

        // start held high: one accepted operand every 17 cycles.
        contin        = 1'b1;
        last_done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        in    = 16'h0100;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            sb.push_back('{16'(k << 8), cyc});
            if (k < 15) begin
                in = 16'((k + 1) << 8);
                repeat (16) @(negedge clk);
            end else begin
                start = 1'b0;
            end
        end
        wait_drain();
        contin = 1'b0;
        check("final_queue", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
